button_event_decoder: RTL



---
 rtl/button_event_decoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release, click,
// double-click and long-press events. Optional saturating click tally: CLICK_COUNTER_EN.
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int DOUBLE_CLICK_GAP  = 300,
  parameter bit ACTIVE_HIGH       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       debounced_in,
  input  logic       cnt_clr,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic       long_active,
  output logic [7:0] click_count
);

  localparam int MAXC = (LONG_PRESS_CYCLES > DOUBLE_CLICK_GAP) ?
                        LONG_PRESS_CYCLES : DOUBLE_CLICK_GAP;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LP_TC = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] DC_TC = CW'(DOUBLE_CLICK_GAP - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          btn;
  logic          btn_q;
  logic          rise;
  logic          fall;

  assign btn  = debounced_in ~^ ACTIVE_HIGH;
  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      btn_q         <= btn;
      press_pulse   <= rise;
      release_pulse <= fall;
    end
  end

  // Terminal counts always leave the counting state, so cnt cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      long_active  <= 1'b0;
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      cnt          <= cnt + ONE;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            state <= PRESSED;
          end
        end
        PRESSED: begin
          if (fall) begin
            state <= WAIT_GAP;
            cnt   <= '0;
          end else if (cnt == LP_TC) begin
            long_press  <= 1'b1;
            long_active <= 1'b1;
            state       <= LONG_HELD;
            cnt         <= '0;
          end
        end
        LONG_HELD: begin
          cnt <= '0;
          if (fall) begin
            long_active <= 1'b0;
            state       <= IDLE;
          end
        end
        WAIT_GAP: begin
          if (rise) begin
            state <= SECOND;
            cnt   <= '0;
          end else if (cnt == DC_TC) begin
            single_click <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
          end
        end
        SECOND: begin
          if (fall) begin
            double_click <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
          end else if (cnt == LP_TC) begin
            single_click <= 1'b1;
            long_press   <= 1'b1;
            long_active  <= 1'b1;
            state        <= LONG_HELD;
            cnt          <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          long_active <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLICK_COUNTER_EN
  logic [8:0] cc_sum;

  assign cc_sum = {1'b0, click_count} +
                  {7'd0, double_click, single_click};

  // Tally follows the registered click pulses; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      click_count <= 8'd0;
    end else if (cnt_clr) begin
      click_count <= 8'd0;
    end else if (cc_sum[8]) begin
      click_count <= 8'hFF;
    end else begin
      click_count <= cc_sum[7:0];
    end
  end
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign click_count    = 8'd0;
`endif

endmodule
